// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// Two half_adder cells plus an OR form a 1-bit full-add slice. The FSM feeds
// that slice one operand bit per clock, LSB first, and holds the carry between
// bits. The result is collected into a WIDTH-bit register and published with
// a start/busy/done handshake.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter only has to reach WIDTH-1; sized for WIDTH+1 so it never wraps early.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_sh_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;

    logic             s1;
    logic             c1;
    logic             s2;
    logic             c2;
    logic             carry_next;
    logic [WIDTH-1:0] res_next;

    // Full-add slice: operand bits first, then fold in the held carry.
    half_adder u_ha_ops (
        .a (a_sh_reg[0]),
        .b (b_sh_reg[0]),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha_carry (
        .a (s1),
        .b (carry_reg),
        .s (s2),
        .c (c2)
    );

    assign carry_next = c1 | c2;

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_single
            assign res_next = s2;
        end else begin : g_res_multi
            assign res_next = {s2, res_sh_reg[WIDTH-1:1]};
        end
    endgenerate

    // Sequencer: capture on start, one bit per RUN cycle, publish on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sum        <= '0;
            cout       <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf        <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_reg   <= a;
                        b_sh_reg   <= b;
                        res_sh_reg <= '0;
                        carry_reg  <= cin;
                        cnt_reg    <= '0;
                        busy       <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    res_sh_reg <= res_next;
                    carry_reg  <= carry_next;
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    if (cnt_reg == LAST_CNT) begin
                        sum       <= res_next;
                        cout      <= carry_next;
`ifdef SERIAL_ADD_OVF_EN
                        // carry_reg here is the carry into the MSB position.
                        ovf       <= carry_reg ^ carry_next;
`endif
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8): vector table plus scoreboard queue,
// with hand-written sequences for held start, mid-run reset and rst+start.
// Build with SERIAL_ADD_OVF_EN defined to also check the ovf output.

module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];
    vec_t exp_q[$];

    int total;
    int bad;
    int done_cnt;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned sum plus signed overflow from carry into/out of the MSB.
    function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        vec_t v;
        logic [W:0]   full;
        logic [W-1:0] low;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        low    = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, ci};
        v.a    = x;
        v.b    = y;
        v.cin  = ci;
        v.sum  = full[W-1:0];
        v.cout = full[W];
        v.ovf  = low[W-1] ^ full[W];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            vec_t e;
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done actual sum=%h cout=%b required no done", sum, cout);
            end else begin
                e = exp_q.pop_front();
                if (sum !== e.sum || cout !== e.cout) begin
                    bad++;
                    $display("FAIL result a=%h b=%h cin=%b actual %b_%h required %b_%h",
                             e.a, e.b, e.cin, cout, sum, e.cout, e.sum);
                end
`ifdef SERIAL_ADD_OVF_EN
                total++;
                if (ovf !== e.ovf) begin
                    bad++;
                    $display("FAIL ovf a=%h b=%h actual=%b required=%b", e.a, e.b, ovf, e.ovf);
                end
`endif
                $display("txn a=%h b=%h cin=%b -> cout=%b sum=%h", e.a, e.b, e.cin, cout, sum);
            end
        end
    end

    // One operation: checks busy length, done position, sum stability during RUN,
    // and ignores operand changes and a stray start while busy.
    task automatic run_op(input vec_t v);
        logic [W-1:0] prev_sum;
        int busy_n;
        int done_at;
        bit stable;
        prev_sum = sum;
        busy_n   = 0;
        done_at  = 0;
        stable   = 1'b1;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        start    = 1'b1;
        exp_q.push_back(v);
        @(posedge clk);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'($urandom);
            end
            if (i == 3) start = 1'b1;
            if (i == 5) start = 1'b0;
            if (busy) busy_n++;
            if (done && done_at == 0) done_at = i;
            if (!done && busy && sum !== prev_sum) stable = 1'b0;
            if (!busy) break;
        end
        check("busy_cycles", 32'(busy_n), 32'(W + 1));
        check("done_position", 32'(done_at), 32'(W + 1));
        check("sum_stable_in_run", 32'(stable), 32'd1);
    endtask

    initial begin
        int dones_seen[$];
        int dc_before;
        bit idle_ok;
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
        vecs[6] = '{a: 8'h12, b: 8'h34, cin: 1'b0, sum: 8'h46, cout: 1'b0, ovf: 1'b0};
        vecs[7] = '{a: 8'hF0, b: 8'h0F, cin: 1'b0, sum: 8'hFF, cout: 1'b0, ovf: 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("reset_ovf", 32'(ovf), 32'd0);
`endif

        // Table vectors, ending with 12+34 followed directly by F0+0F.
        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Random vectors scored against the model.
        for (int i = 0; i < 6; i++) run_op(model(W'($urandom), W'($urandom), 1'($urandom)));

        // start held high for 20 edges: exactly two operations, 10 cycles apart.
        a     = 8'h03;
        b     = 8'h04;
        cin   = 1'b0;
        start = 1'b1;
        exp_q.push_back('{a: 8'h03, b: 8'h04, cin: 1'b0, sum: 8'h07, cout: 1'b0, ovf: 1'b0});
        exp_q.push_back('{a: 8'h03, b: 8'h04, cin: 1'b0, sum: 8'h07, cout: 1'b0, ovf: 1'b0});
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            if (c == 19) start = 1'b0;
            if (done) dones_seen.push_back(c);
        end
        check("held_start_pulses", 32'(dones_seen.size()), 32'd2);
        if (dones_seen.size() == 2)
            check("held_start_spacing", 32'(dones_seen[1] - dones_seen[0]), 32'd10);

        // Reset during the 4th RUN cycle aborts the operation.
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        dc_before = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc_before), 32'd0);

        // rst and start together: request dropped.
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        idle_ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (busy || done) idle_ok = 1'b0;
        end
        check("rst_start_dropped", 32'(idle_ok), 32'd1);

        // One more operation after the resets to confirm recovery.
        run_op(model(8'h3C, 8'hC4, 1'b1));

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
